// File: rtl/scr_fault_pkg.sv
// Shared constants for the SCR fault latch: channel map and default timing.
package scr_fault_pkg;

    localparam int NUM_CH         = 4;

    // Bit positions in o_alarm
    localparam int CH_FWD_STATE   = 0;
    localparam int CH_NEG_STATE   = 1;
    localparam int CH_FWD_BOD     = 2;
    localparam int CH_NEG_BOD     = 3;

    // Defaults sized for the 50 MHz board clock
    localparam int CONFIRM_N_DEF  = 3;
    localparam int TIMEOUT_DEF    = 1000000;
    localparam int BLINK_HALF_DEF = 12500000;

endpackage

// File: rtl/scr_fault_channel.sv
// One fault channel: arm bit, saturating confirm counter and alarm latch.
// flush drops arm/count (forbid or clear); clr additionally drops the alarm.
module scr_fault_channel
    import scr_fault_pkg::*;
#(
    parameter int CONFIRM_N = CONFIRM_N_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic stb,
    input  logic flag,
    input  logic flush,
    input  logic clr,
    output logic alarm
);

    localparam logic [3:0] CNT_MAX = 4'(CONFIRM_N);

    logic       arm_q,   arm_d;
    logic [3:0] cnt_q,   cnt_d;
    logic       alarm_q, alarm_d;

    // Next state: clear beats everything, so a colliding strobe is discarded
    always_comb begin
        arm_d   = arm_q;
        cnt_d   = cnt_q;
        alarm_d = alarm_q;
        if (clr) begin
            arm_d   = 1'b0;
            cnt_d   = '0;
            alarm_d = 1'b0;
        end else if (flush) begin
            arm_d = 1'b0;
            cnt_d = '0;
        end else if (stb) begin
            if (!arm_q) begin
                // first strobe only arms: the detector result is stale here
                arm_d = 1'b1;
            end else if (flag) begin
                cnt_d = (cnt_q >= CNT_MAX) ? CNT_MAX : cnt_q + 4'd1;
                if (cnt_d == CNT_MAX) alarm_d = 1'b1;
            end else begin
                cnt_d = '0;
            end
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arm_q   <= 1'b0;
            cnt_q   <= '0;
            alarm_q <= 1'b0;
        end else begin
            arm_q   <= arm_d;
            cnt_q   <= cnt_d;
            alarm_q <= alarm_d;
        end
    end

    assign alarm = alarm_q;

endmodule

// File: rtl/scr_fault_latch.sv
// SCR fault latch: synchronises trigger/forbid/clear pins, confirms detector
// flags per channel, drives a blinking alarm LED and a trigger-loss flag.
module scr_fault_latch
    import scr_fault_pkg::*;
#(
    parameter int CONFIRM_N  = CONFIRM_N_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF,
    parameter int BLINK_HALF = BLINK_HALF_DEF
) (
    input  logic              i_clk_50m,
    input  logic              i_rst_n,
    input  logic              i_signal_forward,
    input  logic              i_signal_negative,
    input  logic              i_signal_forbid,
    input  logic              i_clear,
    input  logic              i_SCR_forward_state,
    input  logic              i_SCR_negative_state,
    input  logic              i_SCR_forward_BOD,
    input  logic              i_SCR_negative_BOD,
    output logic [NUM_CH-1:0] o_alarm,
    output logic              o_alarm_any,
    output logic              o_led,
    output logic              o_trig_lost
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    // Pin bundle order: {clear, forbid, negative, forward}
    logic [3:0] meta_q, meta_d, sync_q, sync_d, prev_q, prev_d;
    logic       forbid, clr_edge, fwd_stb, neg_stb, flush;

    logic [NUM_CH-1:0] ch_stb, ch_flag, alarm;

    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          lost_q, lost_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          led_q, led_d, act_q, act_d, any;

    // Two-flop synchroniser plus one delay flop for edge detection
    always_comb begin
        meta_d = {i_clear, i_signal_forbid, i_signal_negative, i_signal_forward};
        sync_d = meta_q;
        prev_d = sync_q;
    end

    assign forbid   = sync_q[2];
    assign clr_edge = sync_q[3] & ~prev_q[3];
    assign fwd_stb  = sync_q[0] & ~prev_q[0] & ~forbid;
    assign neg_stb  = sync_q[1] & ~prev_q[1] & ~forbid;
    assign flush    = forbid | clr_edge;

    // Forward edges judge the negative-side result and vice versa
    always_comb begin
        ch_stb                = '0;
        ch_flag               = '0;
        ch_stb[CH_FWD_STATE]  = neg_stb;
        ch_stb[CH_NEG_STATE]  = fwd_stb;
        ch_stb[CH_FWD_BOD]    = fwd_stb;
        ch_stb[CH_NEG_BOD]    = neg_stb;
        ch_flag[CH_FWD_STATE] = i_SCR_forward_state;
        ch_flag[CH_NEG_STATE] = i_SCR_negative_state;
        ch_flag[CH_FWD_BOD]   = i_SCR_forward_BOD;
        ch_flag[CH_NEG_BOD]   = i_SCR_negative_BOD;
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        scr_fault_channel #(.CONFIRM_N(CONFIRM_N)) u_ch (
            .clk   (i_clk_50m),
            .rst_n (i_rst_n),
            .stb   (ch_stb[g]),
            .flag  (ch_flag[g]),
            .flush (flush),
            .clr   (clr_edge),
            .alarm (alarm[g])
        );
    end

    assign any = |alarm;

    // Trigger-loss watchdog: held at zero while forbidden, saturates at TIMEOUT
    always_comb begin
        tcnt_d = tcnt_q;
        if (forbid || fwd_stb || neg_stb) tcnt_d = '0;
        else if (tcnt_q != TW'(TIMEOUT))  tcnt_d = tcnt_q + 1'b1;
        lost_d = (tcnt_q == TW'(TIMEOUT)) & ~forbid;
    end

    // LED blink: switch on right after the first alarm, then toggle each half period
    always_comb begin
        bcnt_d = '0;
        led_d  = 1'b0;
        act_d  = any;
        if (any) begin
            if (!act_q) begin
                led_d = 1'b1;
            end else if (bcnt_q == BW'(BLINK_HALF - 1)) begin
                led_d = ~led_q;
            end else begin
                led_d  = led_q;
                bcnt_d = bcnt_q + 1'b1;
            end
        end
    end

    // Registers
    always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= '0;
            tcnt_q <= '0;
            lost_q <= 1'b0;
            bcnt_q <= '0;
            led_q  <= 1'b0;
            act_q  <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
            tcnt_q <= tcnt_d;
            lost_q <= lost_d;
            bcnt_q <= bcnt_d;
            led_q  <= led_d;
            act_q  <= act_d;
        end
    end

    assign o_alarm     = alarm;
    assign o_alarm_any = any;
    assign o_led       = led_q;
    assign o_trig_lost = lost_q;

endmodule

// File: tb/tb_scr_fault_latch.sv
// Directed bench for scr_fault_latch with a queue of expected alarm vectors.
module tb_scr_fault_latch;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       fwd = 1'b0, neg = 1'b0, forbid = 1'b0, clr = 1'b0;
    logic       f_state = 1'b0, n_state = 1'b0, f_bod = 1'b0, n_bod = 1'b0;
    logic [3:0] alarm;
    logic       alarm_any, led, lost;

    int checks   = 0;
    int failures = 0;
    logic [3:0] exp_q[$];

    always #5 clk = ~clk;

    scr_fault_latch #(.CONFIRM_N(3), .TIMEOUT(100), .BLINK_HALF(10)) dut (
        .i_clk_50m            (clk),
        .i_rst_n              (rst_n),
        .i_signal_forward     (fwd),
        .i_signal_negative    (neg),
        .i_signal_forbid      (forbid),
        .i_clear              (clr),
        .i_SCR_forward_state  (f_state),
        .i_SCR_negative_state (n_state),
        .i_SCR_forward_BOD    (f_bod),
        .i_SCR_negative_BOD   (n_bod),
        .o_alarm              (alarm),
        .o_alarm_any          (alarm_any),
        .o_led                (led),
        .o_trig_lost          (lost)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Pin pulse long enough for the synchroniser to see both edges
    task automatic pulse(input logic f, input logic n, input logic c);
        @(negedge clk);
        fwd = f; neg = n; clr = c;
        repeat (3) @(negedge clk);
        fwd = 1'b0; neg = 1'b0; clr = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic expect_alarm(input logic [3:0] e);
        exp_q.push_back(e);
    endtask

    task automatic drain(input string tag);
        logic [3:0] e;
        e = exp_q.pop_front();
        chk(tag, 32'(alarm), 32'(e));
    endtask

    // Cycles until o_led changes, bounded
    task automatic led_gap(output int n);
        logic l0;
        l0 = led;
        n  = 0;
        while (led === l0 && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int n;
        logic seen;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_alarm", 32'(alarm), 0);
        chk("rst_any",   32'(alarm_any), 0);
        chk("rst_led",   32'(led), 0);
        chk("rst_lost",  32'(lost), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Confirm: fwd_state=1, both triggers together, arm + 3 samples
        f_state = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pulse(1'b1, 1'b1, 1'b0);
            expect_alarm((i == 3) ? 4'b0001 : 4'b0000);
            drain("confirm");
        end
        chk("confirm_any", 32'(alarm_any), 1);
        led_gap(n);
        led_gap(n);
        chk("led_half1", 32'(n), 10);
        led_gap(n);
        chk("led_half2", 32'(n), 10);

        // Async reset mid-blink
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_alarm", 32'(alarm), 0);
        chk("arst_any",   32'(alarm_any), 0);
        chk("arst_led",   32'(led), 0);
        chk("arst_lost",  32'(lost), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("post_rst_alarm", 32'(alarm), 0);
        chk("post_rst_led",   32'(led), 0);

        // Break in the run: 1,1,0,1,1 must not latch; the next 1 does
        f_state = 1'b0;
        f_bod   = 1'b1;
        pulse(1'b1, 1'b0, 1'b0);                 // arm
        for (int i = 0; i < 5; i++) begin
            f_bod = (i != 2);
            pulse(1'b1, 1'b0, 1'b0);
            expect_alarm(4'b0000);
            drain("break");
        end
        f_bod = 1'b1;
        pulse(1'b1, 1'b0, 1'b0);
        expect_alarm(4'b0100);
        drain("break_set");

        // Clear
        f_bod = 1'b0;
        pulse(1'b0, 1'b0, 1'b1);
        expect_alarm(4'b0000);
        drain("clear");
        repeat (3) @(negedge clk);
        chk("clear_led", 32'(led), 0);

        // Forbid after 2 hits on neg_BOD; no trigger-loss while forbidden
        n_bod = 1'b1;
        pulse(1'b0, 1'b1, 1'b0);                 // arm
        pulse(1'b0, 1'b1, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        forbid = 1'b1;
        seen = 1'b0;
        repeat (4) @(negedge clk);
        pulse(1'b0, 1'b1, 1'b0);                 // ignored
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (lost !== 1'b0) seen = 1'b1;
        end
        chk("forbid_lost", 32'(seen), 0);
        forbid = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            pulse(1'b0, 1'b1, 1'b0);
            expect_alarm(4'b0000);
            drain("forbid_rearm");
        end
        pulse(1'b0, 1'b1, 1'b0);
        expect_alarm(4'b1000);
        drain("forbid_set");

        // Clear arriving with the 3rd hit wins and also drops cnt/arm
        n_bod = 1'b0;
        pulse(1'b0, 1'b0, 1'b1);
        f_state = 1'b1;
        pulse(1'b0, 1'b1, 1'b0);                 // arm
        pulse(1'b0, 1'b1, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        pulse(1'b0, 1'b1, 1'b1);                 // 3rd hit + clear
        expect_alarm(4'b0000);
        drain("collide");
        chk("collide_led", 32'(led), 0);
        for (int i = 0; i < 3; i++) begin
            pulse(1'b0, 1'b1, 1'b0);
            expect_alarm(4'b0000);
            drain("collide_after");
        end
        pulse(1'b0, 1'b1, 1'b0);
        expect_alarm(4'b0001);
        drain("collide_reset_ok");

        // Timeout: the last strobe was a few cycles before the pulse task returned
        n = 0;
        while (lost !== 1'b1 && n < 130) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_set", 32'(lost), 1);
        chk("timeout_window", 32'(n >= 90 && n <= 105), 1);
        @(negedge clk);
        fwd = 1'b1;
        @(negedge clk);
        chk("timeout_hold", 32'(lost), 1);        // still inside synchroniser
        repeat (4) @(negedge clk);
        chk("timeout_drop", 32'(lost), 0);
        fwd = 1'b0;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
